serial_add_sequencer: RTL and testbench
=======================================

# serial_add_sequencer

Host-side driver for the team's bit-serial full-adder slice. Accepts a pair of WIDTH-bit operands plus carry-in over a valid/ready handshake. Feeds the slice one bit position per step, LSB first, on its A/B/CIN inputs, captures the returned S/COUT, and feeds each captured COUT back as the next bit's carry-in. Presents the assembled WIDTH-bit sum and final carry on a result valid/ready handshake.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 2..32.
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  high only in IDLE.
- `op_a`  in  WIDTH  operand A.
- `op_b`  in  WIDTH  operand B.
- `cin`  in  1  initial carry-in.
- `abort`  in  1  synchronous cancel of an operation in flight.
- `slice_valid`  out  1  bits on `a_bit`/`b_bit`/`c_bit` are being presented.
- `a_bit`, `b_bit`, `c_bit`  out  1 each  slice inputs A, B, CIN.
- `s_in`, `cout_in`  in  1 each  slice outputs S and COUT; registered in the slice, so valid one cycle after presentation.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumer ready.
- `sum`  out  WIDTH  assembled sum.
- `cout`  out  1  final carry.
- `mismatch`  out  1  self-check flag; see Configuration.

## Operation
- States: IDLE, DRIVE, CAPT, DONE.
- Internal registers: `a_sh`, `b_sh`, `carry`, `idx` (clog2(WIDTH) bits), `sum_r`.

**IDLE**
- `in_ready`=1.
- On `in_valid`: latch `op_a`/`op_b` into the shift registers, load `carry`=`cin`, clear `idx`, go to DRIVE.

**DRIVE**
- `slice_valid`=1.
- `a_bit`=`a_sh[0]`, `b_bit`=`b_sh[0]`, `c_bit`=`carry`.
- Next state: CAPT.

**CAPT**
- `slice_valid`=0.
- Sample `s_in` into `sum_r[idx]`, `cout_in` into `carry`.
- Shift `a_sh`/`b_sh` right by one.
- If `idx`==WIDTH-1, go to DONE; otherwise increment `idx` and go to DRIVE.

**DONE**
- `res_valid`=1, `sum`=`sum_r`, `cout`=`carry`.
- `sum`/`cout` are held stable until `res_ready`.
- On `res_ready`, go to IDLE.

**Carry and width rules**
- The carry chain is carried only through `cout_in`. The block never computes a sum itself, except under the self-check macro.
- `idx` never exceeds WIDTH-1.

**Boundary conditions**
- `abort` in DRIVE, CAPT or DONE: go to IDLE next cycle; no `res_valid` is produced and `sum_r` is discarded.
- `abort` in IDLE is ignored. `abort` together with `in_valid` in IDLE: the request is accepted.
- `res_ready` high before or while entering DONE: the result is consumed in the first DONE cycle, so `res_valid` is high for exactly one cycle.
- `in_valid` while not in IDLE: ignored (`in_ready`=0); operands are not sampled.
- `rst` asserted mid-operation: immediate return to IDLE with all outputs at reset values. The slice is not notified; it sees `slice_valid`=0.
- `s_in`/`cout_in` are sampled only in CAPT and ignored in every other state.

**Reset values**
- State=IDLE, so `in_ready`=1.
- `slice_valid`, `a_bit`, `b_bit`, `c_bit`, `res_valid`, `cout`, `mismatch` = 0.
- `sum` = 0.

## Timing
- Accept edge = the rising edge where `in_valid`&&`in_ready`.
- Bit k is presented in cycle 2k+1 after the accept edge and captured at the end of cycle 2k+2.
- `res_valid` rises 2·WIDTH+1 cycles after the accept edge; for WIDTH=8, 17 cycles.
- Minimum request-to-request spacing: 2·WIDTH+2 cycles, including the one DONE cycle and the return to IDLE.
- All outputs are driven from registers or decoded from the state register only; no combinational path from any input to any output.

## Configuration
- Macro: `SERIAL_ADD_SEQUENCER_CHECK_EN`.
- **Defined:**
  - A reference sum `{ref_c, ref_s}` = `op_a` + `op_b` + `cin` (WIDTH+1 bits) is latched at accept.
  - On entry to DONE, `mismatch` = (`{carry, sum_r}` != `{ref_c, ref_s}`).
  - `mismatch` is held through DONE and cleared on leaving DONE.
- **Undefined:** no reference logic is built; `mismatch` is tied 0. The port exists in both builds.

## Test plan
All scenarios use WIDTH=8 and a bench model of the slice as a registered full adder.
- **Basic add:** `op_a`=0xA5, `op_b`=0x3C, `cin`=1 -> `sum`=0xE2, `cout`=0, `res_valid` at cycle 17, `mismatch`=0.
- **Full carry ripple:** `op_a`=0xFF, `op_b`=0x01, `cin`=0 -> `sum`=0x00, `cout`=1. `c_bit`=1 presented for bits 1..7.
- **Back-pressure:** hold `res_ready`=0 for 5 cycles after `res_valid` -> `sum`/`cout` stable and `in_ready`=0 throughout. Raising `res_ready` returns the block to IDLE one cycle later.
- **Abort:** assert `abort` in the 3rd DRIVE cycle -> IDLE next cycle, `slice_valid`=0, no `res_valid`. A following request 0x10+0x20+0 -> `sum`=0x30.
- **Reset mid-operation:** pulse `rst` during CAPT of bit 4 -> all outputs return to reset values immediately and `in_ready`=1. A following request 0x7F+0x7F+1 -> `sum`=0xFF, `cout`=0.
- **Self-check (macro defined):** bench model corrupts S on bit 2 -> `mismatch`=1 in DONE. Macro undefined -> `mismatch`=0.

Source files
------------

// File: rtl/serial_add_sequencer.sv
// Host-side sequencer for a registered bit-serial full-adder slice, LSB first.
// Optional reference self-check: define SERIAL_ADD_SEQUENCER_CHECK_EN.
module serial_add_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   input  logic             abort,
   output logic             slice_valid,
   output logic             a_bit,
   output logic             b_bit,
   output logic             c_bit,
   input  logic             s_in,
   input  logic             cout_in,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             mismatch
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      CAPT,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic             carry_q, carry_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] sum_q, sum_d;

`ifdef SERIAL_ADD_SEQUENCER_CHECK_EN
   logic [WIDTH:0]   ref_q, ref_d;
   logic             mis_q, mis_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
`ifdef SERIAL_ADD_SEQUENCER_CHECK_EN
         ref_q   <= '0;
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
`ifdef SERIAL_ADD_SEQUENCER_CHECK_EN
         ref_q   <= ref_d;
         mis_q   <= mis_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
`ifdef SERIAL_ADD_SEQUENCER_CHECK_EN
      ref_d   = ref_q;
      mis_d   = mis_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d  = op_a;
               b_sh_d  = op_b;
               carry_d = cin;
               idx_d   = '0;
               sum_d   = '0;
`ifdef SERIAL_ADD_SEQUENCER_CHECK_EN
               ref_d   = {1'b0, op_a} + {1'b0, op_b}
                       + {{WIDTH{1'b0}}, cin};
`endif
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            state_d = abort ? IDLE : CAPT;
         end
         CAPT: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               sum_d[idx_q] = s_in;
               carry_d      = cout_in;
               a_sh_d       = a_sh_q >> 1;
               b_sh_d       = b_sh_q >> 1;
               if (idx_q == LAST) begin
                  state_d = DONE;
`ifdef SERIAL_ADD_SEQUENCER_CHECK_EN
                  mis_d   = ({cout_in, sum_d} != ref_q);
`endif
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = DRIVE;
               end
            end
         end
         DONE: begin
            if (abort || res_ready) begin
               state_d = IDLE;
`ifdef SERIAL_ADD_SEQUENCER_CHECK_EN
               mis_d   = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode only the state and registers; inputs never reach them.
   assign in_ready    = (state_q == IDLE);
   assign slice_valid = (state_q == DRIVE);
   assign a_bit       = slice_valid & a_sh_q[0];
   assign b_bit       = slice_valid & b_sh_q[0];
   assign c_bit       = slice_valid & carry_q;
   assign res_valid   = (state_q == DONE);
   assign sum         = res_valid ? sum_q : '0;
   assign cout        = res_valid & carry_q;

`ifdef SERIAL_ADD_SEQUENCER_CHECK_EN
   assign mismatch = mis_q;
`else
   assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer with a registered full-adder slice model.
module tb_serial_add_sequencer;

   localparam int W = 8;

`ifdef SERIAL_ADD_SEQUENCER_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready;
   logic [W-1:0] op_a, op_b;
   logic         cin, abort;
   logic         slice_valid, a_bit, b_bit, c_bit;
   logic         s_in, cout_in;
   logic         res_valid, res_ready;
   logic [W-1:0] sum;
   logic         cout, mismatch;

   int vectors = 0;
   int miscompares = 0;
   int corrupt_bit = -1;
   int pres_cnt;

   serial_add_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .cin(cin), .abort(abort),
      .slice_valid(slice_valid),
      .a_bit(a_bit), .b_bit(b_bit), .c_bit(c_bit),
      .s_in(s_in), .cout_in(cout_in),
      .res_valid(res_valid), .res_ready(res_ready),
      .sum(sum), .cout(cout), .mismatch(mismatch)
   );

   always #5 clk = ~clk;

   // Slice model: registered full adder; junk when not presented.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pres_cnt <= 0;
         s_in     <= 1'b0;
         cout_in  <= 1'b0;
      end else if (slice_valid) begin
         s_in     <= (a_bit ^ b_bit ^ c_bit) ^ (pres_cnt == corrupt_bit);
         cout_in  <= (a_bit & b_bit) | (a_bit & c_bit) | (b_bit & c_bit);
         pres_cnt <= pres_cnt + 1;
      end else begin
         s_in    <= 1'($urandom);
         cout_in <= 1'($urandom);
         if (in_valid && in_ready) pres_cnt <= 0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Runs one transaction from IDLE; called #1 after a rising edge.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input int bp, input bit noise,
                        input bit abrt, output logic [W-1:0] s,
                        output logic co, output logic mis);
      int cnt, k, m;
      logic [W-1:0] av, bv, cv, ce;
      chk("in_ready_idle", in_ready, 1);
      op_a = a; op_b = b; cin = c;
      in_valid = 1'b1; abort = abrt; res_ready = (bp == 0);
      @(posedge clk); #1;
      in_valid = 1'b0; abort = 1'b0;
      op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
      cnt = 1; k = 0; av = '0; bv = '0; cv = '0;
      while (!res_valid && cnt < 60) begin
         if (slice_valid && k < W) begin
            av[k] = a_bit; bv[k] = b_bit; cv[k] = c_bit; k++;
         end
         if (noise) begin
            in_valid = (cnt >= 3 && cnt < 10);
            op_a = W'($urandom); op_b = W'($urandom);
            cin = 1'($urandom);
         end
         @(posedge clk); #1;
         cnt++;
      end
      in_valid = 1'b0;
      chk("latency", cnt, 2 * W + 1);
      for (int j = 0; j < W; j++) begin
         m = (1 << j) - 1;
         ce[j] = 1'(((int'(a) & m) + (int'(b) & m) + int'(c)) >> j);
      end
      chk("slice_bits", {av, bv, cv}, {a, b, ce});
      s = sum; co = cout; mis = mismatch;
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         chk("hold", {res_valid, in_ready, cout, sum},
             {1'b1, 1'b0, co, s});
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("release", {res_valid, in_ready, mismatch}, 3'b010);
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      int           bp;
      int           corrupt;
      bit           abrt;
      logic [W-1:0] es;
      logic         ec;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [W-1:0] s;
      logic co, mis;
      logic [W:0] exp;
      int rv;
      logic [W-1:0] ra, rb;
      logic rc;

      tbl[0] = '{8'hA5, 8'h3C, 1'b1, 0, -1, 1'b0, 8'hE2, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 0, -1, 1'b0, 8'h00, 1'b1};
      tbl[2] = '{8'h80, 8'h80, 1'b1, 5, -1, 1'b0, 8'h01, 1'b1};
      tbl[3] = '{8'h12, 8'h34, 1'b0, 1, -1, 1'b1, 8'h46, 1'b0};
      tbl[4] = '{8'h00, 8'h00, 1'b0, 0, -1, 1'b0, 8'h00, 1'b0};
      tbl[5] = '{8'h0F, 8'h01, 1'b0, 0,  2, 1'b0, 8'h14, 1'b0};

      rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
      abort = 1'b0; res_ready = 1'b0;
      #12;
      chk("reset", {in_ready, slice_valid, a_bit, b_bit, c_bit,
                    res_valid, cout, mismatch, sum}, 16'h8000);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         corrupt_bit = tbl[i].corrupt;
         do_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].bp, 1'b0,
               tbl[i].abrt, s, co, mis);
         chk($sformatf("vec%0d_sum", i), {co, s}, {tbl[i].ec, tbl[i].es});
         chk($sformatf("vec%0d_mis", i), mis,
             (tbl[i].corrupt >= 0) ? CHK : 1'b0);
      end
      corrupt_bit = -1;

      // Abort in the third DRIVE cycle.
      op_a = 8'h55; op_b = 8'h66; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("abort_drive3", {slice_valid, in_ready}, 2'b10);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_idle", {in_ready, slice_valid, res_valid}, 3'b100);
      rv = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (res_valid) rv++;
      end
      chk("abort_no_res", rv, 0);
      do_op(8'h10, 8'h20, 1'b0, 0, 1'b0, 1'b0, s, co, mis);
      chk("after_abort", {co, s}, 9'h030);

      // Reset during CAPT of bit 4.
      op_a = 8'hC3; op_b = 8'h5A; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      chk("capt_bit4", {slice_valid, in_ready, res_valid}, 3'b000);
      rst = 1'b1;
      #1;
      chk("reset_mid", {in_ready, slice_valid, a_bit, b_bit, c_bit,
                        res_valid, cout, mismatch, sum}, 16'h8000);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      do_op(8'h7F, 8'h7F, 1'b1, 0, 1'b0, 1'b0, s, co, mis);
      chk("after_reset", {co, s}, 9'h0FF);

      // Random operands, back-pressure and ignored mid-flight requests.
      for (int n = 0; n < 30; n++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         exp = (W+1)'(int'(ra) + int'(rb) + int'(rc));
         do_op(ra, rb, rc, int'($urandom_range(0, 3)), 1'b1, 1'b0,
               s, co, mis);
         chk("rand_sum", {co, s}, exp);
         chk("rand_mis", mis, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
